// File: rtl/button_events.sv
// rtl/button_events.sv - press/release/auto-repeat event scheduler for panel buttons
// Edge-detected and timed events are held as 1-deep pending bits and arbitrated round-robin onto one stream.
module button_events #(
  parameter int N            = 8,
  parameter int TICKS_PER_MS = 98000,
  parameter int HOLD_MS      = 500,
  parameter int REPEAT_MS    = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         btn,
  output logic [N-1:0]         held,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [$clog2(N)-1:0] ev_id,
  output logic [1:0]           ev_kind
);

  localparam int IW = $clog2(N);
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LOAD = PW'(TICKS_PER_MS - 1);
  localparam logic [9:0]    HOLD_LOAD  = 10'(HOLD_MS - 1);
  localparam logic [9:0]    REP_LOAD   = 10'(REPEAT_MS - 1);
  localparam logic [1:0]    KIND_PRESS = 2'd0;
  localparam logic [1:0]    KIND_REL   = 2'd1;
  localparam logic [1:0]    KIND_REP   = 2'd2;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

  logic [N-1:0]    press_edge, rel_edge;
  logic [N-1:0]    press_pend, rel_pend, rep_pend;
  logic [N-1:0]    press_clr, rel_clr, rep_clr, rep_set;
  logic [PW-1:0]   presc;
  logic            ms_tick;
  rep_state_t      state, state_nxt;
  logic [9:0]      timer, timer_nxt;
  logic [IW-1:0]   rep_btn, rep_btn_nxt;
  logic            found_press;
  logic [IW-1:0]   rr;
  logic            free, found, take;
  logic [IW-1:0]   gnt_id, idx;
  logic [1:0]      gnt_kind;
  int              scan_idx;

  assign press_edge = btn & ~held;
  assign rel_edge   = ~btn & held;
  assign ms_tick    = (presc == '0);
  assign free       = !ev_valid || ev_ready;
  assign take       = free && found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (ms_tick) begin
      presc <= PRESC_LOAD;
    end else begin
      presc <= presc - PW'(1);
    end
  end

  // A new press always retargets the shared timer; releasing the tracked button beats a same-cycle expiry.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    rep_btn_nxt = rep_btn;
    rep_set     = '0;
    found_press = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (press_edge[i] && !found_press) begin
        found_press = 1'b1;
        rep_btn_nxt = IW'(i);
      end
    end
    if (found_press) begin
      timer_nxt = HOLD_LOAD;
      state_nxt = HOLD;
    end else if (state != IDLE && rel_edge[rep_btn]) begin
      state_nxt = IDLE;
    end else if (state != IDLE && ms_tick) begin
      if (timer == '0) begin
        rep_set[rep_btn] = 1'b1;
        timer_nxt        = REP_LOAD;
        state_nxt        = REPEAT;
      end else begin
        timer_nxt = timer - 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      rep_btn <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      rep_btn <= rep_btn_nxt;
    end
  end

  always_comb begin
    found     = 1'b0;
    gnt_id    = '0;
    gnt_kind  = KIND_PRESS;
    press_clr = '0;
    rel_clr   = '0;
    rep_clr   = '0;
    scan_idx  = 0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(rr) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      idx = IW'(scan_idx);
      if (!found && (press_pend[idx] || rel_pend[idx] || rep_pend[idx])) begin
        found  = 1'b1;
        gnt_id = idx;
        // With both edges pending, the current level tells which came first.
        if (press_pend[idx] && (!rel_pend[idx] || !held[idx])) begin
          gnt_kind       = KIND_PRESS;
          press_clr[idx] = 1'b1;
        end else if (rel_pend[idx]) begin
          gnt_kind     = KIND_REL;
          rel_clr[idx] = 1'b1;
        end else begin
          gnt_kind     = KIND_REP;
          rep_clr[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held       <= '0;
      press_pend <= '0;
      rel_pend   <= '0;
      rep_pend   <= '0;
    end else begin
      held       <= btn;
      press_pend <= (press_pend & ~(press_clr & {N{take}})) | press_edge;
      rel_pend   <= (rel_pend & ~(rel_clr & {N{take}})) | rel_edge;
      rep_pend   <= (rep_pend & ~(rep_clr & {N{take}}) & ~rel_edge) | rep_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_kind  <= KIND_PRESS;
      rr       <= '0;
    end else if (free) begin
      if (found) begin
        ev_valid <= 1'b1;
        ev_id    <= gnt_id;
        ev_kind  <= gnt_kind;
        rr       <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule
